// File: rtl/tankb_video_pkg.sv
// Shared timing defaults and tile-address layout for the Tank Battalion video timing block.
package tankb_video_pkg;

    localparam int unsigned H_TOTAL      = 384;
    localparam int unsigned H_ACTIVE     = 256;
    localparam int unsigned H_SYNC_START = 288;
    localparam int unsigned H_SYNC_LEN   = 32;
    localparam int unsigned V_TOTAL      = 264;
    localparam int unsigned V_ACTIVE     = 224;
    localparam int unsigned V_SYNC_START = 240;
    localparam int unsigned V_SYNC_LEN   = 8;

    localparam int unsigned CNT_W  = 9;
    localparam int unsigned ROW_W  = 5;
    localparam int unsigned COL_W  = 5;
    localparam int unsigned ADDR_W = ROW_W + COL_W;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } tile_addr_t;

endpackage

// File: rtl/tankb_wrap_counter.sv
// 9-bit wrapping counter with enable; exposes its next value so decodes can be registered
// in step with the count.
module tankb_wrap_counter
    import tankb_video_pkg::*;
#(
    parameter int unsigned Total = 384
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_next,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;

    assign cnt = cnt_q;
    assign tc  = (cnt_q == CNT_W'(Total - 1));

    always_comb begin
        cnt_next = cnt_q;
        if (en) begin
            cnt_next = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_next;
        end
    end

endmodule

// File: rtl/tankb_video_timing.sv
// Raster timing generator: counters, syncs, blanks and shifter tile-fetch address/load strobe.
// Optional cocktail flip of tile_addr is enabled by defining TANKB_FLIP_EN.
module tankb_video_timing
    import tankb_video_pkg::*;
#(
    parameter int unsigned HTotal     = H_TOTAL,
    parameter int unsigned HActive    = H_ACTIVE,
    parameter int unsigned HSyncStart = H_SYNC_START,
    parameter int unsigned HSyncLen   = H_SYNC_LEN,
    parameter int unsigned VTotal     = V_TOTAL,
    parameter int unsigned VActive    = V_ACTIVE,
    parameter int unsigned VSyncStart = V_SYNC_START,
    parameter int unsigned VSyncLen   = V_SYNC_LEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_pix,
    input  logic              flip,
    output logic [CNT_W-1:0]  h_cnt,
    output logic [CNT_W-1:0]  v_cnt,
    output logic              hsync_n,
    output logic              vsync_n,
    output logic              hblank,
    output logic              vblank,
    output logic              shift_load_n,
    output logic [ADDR_W-1:0] tile_addr,
    output logic              line_start,
    output logic              frame_start
);

    if (HTotal > 512 || VTotal > 512 || HSyncStart + HSyncLen > HTotal ||
        VSyncStart + VSyncLen > VTotal || (HActive % 8) != 0) begin : g_bad_params
        $error("tankb_video_timing: illegal timing parameters");
    end

    logic [CNT_W-1:0] h_next, v_next;
    logic             h_tc, v_tc;

    tankb_wrap_counter #(.Total(HTotal)) u_h_cnt (
        .clk      (clk),
        .reset    (reset),
        .en       (ce_pix),
        .cnt      (h_cnt),
        .cnt_next (h_next),
        .tc       (h_tc)
    );

    tankb_wrap_counter #(.Total(VTotal)) u_v_cnt (
        .clk      (clk),
        .reset    (reset),
        .en       (ce_pix & h_tc),
        .cnt      (v_cnt),
        .cnt_next (v_next),
        .tc       (v_tc)
    );

    logic [CNT_W-1:0] h_plus;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    tile_addr_t       addr_d, addr_q;
    logic             hsync_n_q, vsync_n_q, hblank_q, vblank_q, load_n_q;
    logic             line_start_q, frame_start_q;

    // The last pixel of a line preloads column 0 rather than the wrapped-by-256 column.
    assign h_plus = h_next + 1'b1;
    assign col    = (h_next == CNT_W'(HTotal - 1)) ? '0 : h_plus[7:3];
    assign row    = v_next[7:3];

    logic unused_bits;
    assign unused_bits = ^{h_plus[8], h_plus[2:0], v_next[8], v_next[2:0]};

`ifdef TANKB_FLIP_EN
    logic flip_q, flip_d;

    // Flip is latched only at the line wrap so a line is never half-flipped.
    assign flip_d = (ce_pix & h_tc) ? flip : flip_q;
    assign addr_d = flip_d ? '{row: ~row, col: ~col} : '{row: row, col: col};

    always_ff @(posedge clk) begin
        if (reset) begin
            flip_q <= 1'b0;
        end else begin
            flip_q <= flip_d;
        end
    end
`else
    logic unused_flip;
    assign unused_flip = flip;
    assign addr_d      = '{row: row, col: col};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            hblank_q      <= 1'b0;
            vblank_q      <= 1'b0;
            load_n_q      <= 1'b1;
            addr_q        <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= ce_pix & h_tc;
            frame_start_q <= ce_pix & h_tc & v_tc;
            if (ce_pix) begin
                hsync_n_q <= !({1'b0, h_next} >= 10'(HSyncStart) &&
                               {1'b0, h_next} <  10'(HSyncStart + HSyncLen));
                vsync_n_q <= !({1'b0, v_next} >= 10'(VSyncStart) &&
                               {1'b0, v_next} <  10'(VSyncStart + VSyncLen));
                hblank_q  <= {1'b0, h_next} >= 10'(HActive);
                vblank_q  <= {1'b0, v_next} >= 10'(VActive);
                load_n_q  <= h_next[2:0] != 3'd7;
                addr_q    <= addr_d;
            end
        end
    end

    assign hsync_n      = hsync_n_q;
    assign vsync_n      = vsync_n_q;
    assign hblank       = hblank_q;
    assign vblank       = vblank_q;
    assign shift_load_n = load_n_q;
    assign tile_addr    = addr_q;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_tankb_video_timing.sv
// Directed bench for tankb_video_timing: table vectors, full-line, load strobe, flip and
// mid-frame reset on the default timing, plus a full frame on a shrunken instance.
module tb_tankb_video_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, ce_pix, flip;
    logic [8:0] h_cnt, v_cnt;
    logic       hsync_n, vsync_n, hblank, vblank, shift_load_n, line_start, frame_start;
    logic [9:0] tile_addr;

    tankb_video_timing dut (
        .clk          (clk),
        .reset        (reset),
        .ce_pix       (ce_pix),
        .flip         (flip),
        .h_cnt        (h_cnt),
        .v_cnt        (v_cnt),
        .hsync_n      (hsync_n),
        .vsync_n      (vsync_n),
        .hblank       (hblank),
        .vblank       (vblank),
        .shift_load_n (shift_load_n),
        .tile_addr    (tile_addr),
        .line_start   (line_start),
        .frame_start  (frame_start)
    );

    // Shrunken raster: 24 pixels x 12 lines, so a whole frame is cheap to walk.
    logic       reset2, ce2;
    logic [8:0] h2, v2;
    logic       hs2, vs2, hb2, vb2, sl2, ls2, fs2;
    logic [9:0] ta2;

    tankb_video_timing #(
        .HTotal     (24),
        .HActive    (16),
        .HSyncStart (18),
        .HSyncLen   (2),
        .VTotal     (12),
        .VActive    (8),
        .VSyncStart (9),
        .VSyncLen   (2)
    ) dut_small (
        .clk          (clk),
        .reset        (reset2),
        .ce_pix       (ce2),
        .flip         (1'b0),
        .h_cnt        (h2),
        .v_cnt        (v2),
        .hsync_n      (hs2),
        .vsync_n      (vs2),
        .hblank       (hb2),
        .vblank       (vb2),
        .shift_load_n (sl2),
        .tile_addr    (ta2),
        .line_start   (ls2),
        .frame_start  (fs2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        ce_pix = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    typedef struct {
        logic       rst;
        logic       ce;
        logic [8:0] h;
        logic [8:0] v;
        logic       hs_n;
        logic       sl_n;
        logic [9:0] tile;
        logic       ls;
    } vec_t;

    vec_t vecs[12];

    int ls_cnt, fs_cnt, eh, ev, ov;
    logic wrap, fs_exp;
    logic [9:0] flip_exp;

    initial begin
        reset = 1'b1; ce_pix = 1'b1; flip = 1'b0;
        reset2 = 1'b1; ce2 = 1'b0;

        vecs[0]  = '{1'b1, 1'b1, 9'd0, 9'd0, 1'b1, 1'b1, 10'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 9'd0, 9'd0, 1'b1, 1'b1, 10'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 9'd1, 9'd0, 1'b1, 1'b1, 10'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 9'd1, 9'd0, 1'b1, 1'b1, 10'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 9'd2, 9'd0, 1'b1, 1'b1, 10'd0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 9'd3, 9'd0, 1'b1, 1'b1, 10'd0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 9'd4, 9'd0, 1'b1, 1'b1, 10'd0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 9'd5, 9'd0, 1'b1, 1'b1, 10'd0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 9'd6, 9'd0, 1'b1, 1'b1, 10'd0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 9'd7, 9'd0, 1'b1, 1'b0, 10'd1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 9'd7, 9'd0, 1'b1, 1'b0, 10'd1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 9'd8, 9'd0, 1'b1, 1'b1, 10'd1, 1'b0};

        for (int i = 0; i < 12; i++) begin
            reset  = vecs[i].rst;
            ce_pix = vecs[i].ce;
            tick();
            chk($sformatf("vec%0d h_cnt", i), 32'(h_cnt), 32'(vecs[i].h));
            chk($sformatf("vec%0d v_cnt", i), 32'(v_cnt), 32'(vecs[i].v));
            chk($sformatf("vec%0d hsync_n", i), 32'(hsync_n), 32'(vecs[i].hs_n));
            chk($sformatf("vec%0d shift_load_n", i), 32'(shift_load_n), 32'(vecs[i].sl_n));
            chk($sformatf("vec%0d tile_addr", i), 32'(tile_addr), 32'(vecs[i].tile));
            chk($sformatf("vec%0d line_start", i), 32'(line_start), 32'(vecs[i].ls));
            chk($sformatf("vec%0d vsync_n", i), 32'(vsync_n), 32'd1);
            chk($sformatf("vec%0d frame_start", i), 32'(frame_start), 32'd0);
        end

        // One full line with ce_pix every second clock.
        reset = 1'b1; ce_pix = 1'b0; tick();
        reset = 1'b0;
        ls_cnt = 0;
        for (int i = 1; i <= 384; i++) begin
            eh = i % 384;
            ce_pix = 1'b1; tick();
            if (line_start === 1'b1) ls_cnt++;
            chk("line h_cnt", 32'(h_cnt), 32'(eh));
            chk("line v_cnt", 32'(v_cnt), (i == 384) ? 32'd1 : 32'd0);
            chk("line hblank", 32'(hblank), 32'(eh >= 256));
            chk("line hsync_n", 32'(hsync_n), 32'(!(eh >= 288 && eh < 320)));
            ce_pix = 1'b0; tick();
            chk("line hold h_cnt", 32'(h_cnt), 32'(eh));
            chk("line hold line_start", 32'(line_start), 32'd0);
        end
        chk("line line_start count", 32'(ls_cnt), 32'd1);

        // Load strobe and tile address across line 17; flip requested mid-line.
        run(16 * 384);
        chk("load v_cnt at 17", 32'(v_cnt), 32'd17);
        for (int h = 1; h < 384; h++) begin
            tick();
            chk("load shift_load_n", 32'(shift_load_n), 32'((h % 8) != 7));
            if (h == 7)   chk("load tile h7", 32'(tile_addr), {22'd0, 5'd2, 5'd1});
            if (h == 101) chk("flip pending tile h101", 32'(tile_addr), {22'd0, 5'd2, 5'd12});
            if (h == 383) chk("load tile h383", 32'(tile_addr), {22'd0, 5'd2, 5'd0});
            if (h == 100) flip = 1'b1;
        end
        run(8);
        chk("flip h_cnt", 32'(h_cnt), 32'd7);
        chk("flip v_cnt", 32'(v_cnt), 32'd18);
`ifdef TANKB_FLIP_EN
        flip_exp = {5'd29, 5'd30};
`else
        flip_exp = {5'd2, 5'd1};
`endif
        chk("flip tile v18 h7", 32'(tile_addr), 32'(flip_exp));
        flip = 1'b0;

        // Reset mid-frame with ce_pix low.
        run(82 * 384 + 193);
        chk("pre-reset h_cnt", 32'(h_cnt), 32'd200);
        chk("pre-reset v_cnt", 32'(v_cnt), 32'd100);
        ce_pix = 1'b0; reset = 1'b1; tick();
        chk("midreset h_cnt", 32'(h_cnt), 32'd0);
        chk("midreset v_cnt", 32'(v_cnt), 32'd0);
        chk("midreset hsync_n", 32'(hsync_n), 32'd1);
        chk("midreset vsync_n", 32'(vsync_n), 32'd1);
        chk("midreset hblank", 32'(hblank), 32'd0);
        chk("midreset vblank", 32'(vblank), 32'd0);
        chk("midreset shift_load_n", 32'(shift_load_n), 32'd1);
        chk("midreset tile_addr", 32'(tile_addr), 32'd0);
        chk("midreset line_start", 32'(line_start), 32'd0);
        chk("midreset frame_start", 32'(frame_start), 32'd0);
        reset = 1'b0; ce_pix = 1'b1; tick();
        chk("post-reset h_cnt", 32'(h_cnt), 32'd1);

        // Full frame on the shrunken instance.
        ce2 = 1'b1; tick();
        reset2 = 1'b0;
        eh = 0; ev = 0; ls_cnt = 0; fs_cnt = 0;
        for (int i = 0; i < 24 * 12; i++) begin
            tick();
            wrap = (eh == 23);
            ov = ev;
            eh = wrap ? 0 : eh + 1;
            if (wrap) ev = (ev == 11) ? 0 : ev + 1;
            fs_exp = wrap && (ov == 11);
            if (ls2 === 1'b1) ls_cnt++;
            if (fs2 === 1'b1) fs_cnt++;
            chk("frame h_cnt", 32'(h2), 32'(eh));
            chk("frame v_cnt", 32'(v2), 32'(ev));
            chk("frame vblank", 32'(vb2), 32'(ev >= 8));
            chk("frame vsync_n", 32'(vs2), 32'(!(ev >= 9 && ev < 11)));
            chk("frame line_start", 32'(ls2), 32'(wrap));
            chk("frame frame_start", 32'(fs2), 32'(fs_exp));
        end
        chk("frame line_start count", 32'(ls_cnt), 32'd12);
        chk("frame frame_start count", 32'(fs_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tankb_video_timing.md
# tankb_video_timing

Raster timing generator for the Tank Battalion video path. Produces horizontal/vertical counters, active-low syncs, blanking, and the tile-fetch address and active-low load strobe for the 74LS166-style pixel shifters. It sits directly upstream of the tile ROM and shifter stage. All outputs are registered and advance only on the pixel clock enable.

## Interface
- H_TOTAL, 384, pixels per line (counter wraps at H_TOTAL-1)
- H_ACTIVE, 256, visible pixels per line; must be a multiple of 8
- H_SYNC_START, 288, first h_cnt with hsync_n low
- H_SYNC_LEN, 32, hsync_n low width in pixels
- V_TOTAL, 264, lines per frame
- V_ACTIVE, 224, visible lines
- V_SYNC_START, 240, first v_cnt with vsync_n low
- V_SYNC_LEN, 8, vsync_n low width in lines
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high
- ce_pix  in  1  pixel clock enable; all state advances only when high
- flip  in  1  cocktail flip request; used only when TANKB_FLIP_EN is defined
- h_cnt  out  9  horizontal pixel counter
- v_cnt  out  9  vertical line counter
- hsync_n  out  1  horizontal sync, active low
- vsync_n  out  1  vertical sync, active low
- hblank  out  1  high when h_cnt >= H_ACTIVE
- vblank  out  1  high when v_cnt >= V_ACTIVE
- shift_load_n  out  1  active-low load for shifters; low while h_cnt[2:0]==7
- tile_addr  out  10  {row[4:0], col[4:0]} of the tile column loaded next
- line_start  out  1  one-clk pulse on the ce_pix that wraps h_cnt to 0
- frame_start  out  1  one-clk pulse on the ce_pix that wraps both counters to 0

## Operation
- Reset, which has priority over ce_pix, sets outputs as follows:
  - h_cnt=0, v_cnt=0
  - hsync_n=1, vsync_n=1
  - hblank=0, vblank=0
  - shift_load_n=1, tile_addr=0
  - line_start=0, frame_start=0
- With ce_pix=0, every output holds. line_start and frame_start are driven 0.
- On ce_pix=1:
  - h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps from V_TOTAL-1 to 0 on that same wrap.
- Decoded outputs are computed from the next counter values and registered, so they are cycle-aligned with h_cnt/v_cnt. There is no extra lag.
- hsync_n is low for H_SYNC_START <= h_cnt < H_SYNC_START+H_SYNC_LEN. vsync_n uses the equivalent rule on v_cnt. Sync and blank decode are independent of flip.
- shift_load_n=0 exactly while h_cnt[2:0]==7. The downstream shifter, clocked on the same ce_pix, therefore loads at the boundary into column pixel 0.
- tile_addr:
  - col = ((h_cnt+1) mod 256)[7:3]
  - row = v_cnt[7:3]
  - During a load interval, this addresses the column about to be displayed.
  - At h_cnt=H_TOTAL-1 the address is col 0, which preloads the first column of the line.
- Width rules: counters are 9-bit unsigned. Parameters must satisfy H_TOTAL <= 512, V_TOTAL <= 512, sync end <= total. Violations are a synthesis-time error.

## Timing
- Latency: zero ce_pix cycles between counter value and its decodes. Every output changes on the clk edge where ce_pix=1.
- Reset asserted mid-frame: counters read 0 on the next clk edge regardless of ce_pix. The first ce_pix after reset release gives h_cnt=1.
- Simultaneous h and v wrap produces line_start=1 and frame_start=1 on the same clk.

## Configuration
- TANKB_FLIP_EN defined, flip=1:
  - tile_addr becomes {~row, ~col}, for a 180° screen.
  - flip is sampled only when line_start fires, so a mid-line change takes effect on the next line.
- TANKB_FLIP_EN defined, flip=0: tile_addr is unflipped.
- TANKB_FLIP_EN undefined: flip is ignored and tile_addr is never inverted. No flip register is synthesized.

## Structure
- Package tankb_video_pkg holds:
  - default timing constants (H_/V_ values above)
  - the tile_addr field widths
  - a typedef for the {row,col} address
- One sub-module, tankb_wrap_counter: 9-bit counter with synchronous reset, enable, parameterized terminal count and terminal-count output. It is instantiated twice, chained h→v by terminal count ANDed with ce_pix.

## Test plan
- Reset with ce_pix held at 1 → h_cnt=0, v_cnt=0, hsync_n=1, vsync_n=1, shift_load_n=1 on the cycle after reset; h_cnt=1 after the first enabled edge.
- ce_pix every 2nd clk for one full line → h_cnt steps 0..383 then back to 0, v_cnt 0→1, one line_start pulse. hblank rises at h_cnt=256; hsync_n is low for h_cnt 288..319.
- Full frame (384×264 enables) → vblank high for v_cnt 224..263, vsync_n low for v_cnt 240..247, exactly one frame_start coinciding with line_start.
- Load strobe at v_cnt=17 → shift_load_n low at h_cnt=7,15,...; at h_cnt=7, tile_addr={5'd2,5'd1}; at h_cnt=383, tile_addr={5'd2,5'd0}.
- TANKB_FLIP_EN defined, flip=1 set mid-line at v_cnt=17 → tile_addr unflipped until the next line_start; at v_cnt=18, h_cnt=7 it reads {5'd29,5'd30}.
- Reset pulse at h_cnt=200, v_cnt=100 with ce_pix=0 → next edge shows h_cnt=0, v_cnt=0, all outputs at their reset values.
